alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator side of the 16-bit ALU operand interface.
- Accepts operation commands (A, B, 3-bit control) over a valid/ready handshake and buffers them in a small FIFO.
- Drives one command at a time onto the combinational alu's A/B/control inputs, captures Out/Zero, and returns the result over a valid/ready response handshake.
- Sits between the datapath controller and the alu module in modules/.

Parameters:
- WIDTH, 16: operand/result width; must match the alu.
- DEPTH, 4: command FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_op  input  3  alu control code, passed through unmodified
- alu_a  output  WIDTH  registered operand to alu.A
- alu_b  output  WIDTH  registered operand to alu.B
- alu_control  output  3  registered code to alu.control
- alu_out  input  WIDTH  from alu.Out
- alu_zero  input  1  from alu.Zero
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  captured alu_out
- rsp_zero  output  1  captured alu_zero
- rsp_op  output  3  control code that produced the result
- busy  output  1  FSM not in IDLE, or FIFO non-empty
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (on the clk edge with reset=1):
  - state=IDLE, count=0, FIFO pointers=0.
  - alu_a/alu_b/alu_control=0; rsp_valid=0; rsp_data/rsp_zero/rsp_op=0.
  - cmd_ready=1 on the cycle after reset deasserts.
- Reset asserted mid-operation discards all FIFO contents and any in-flight or held result. No response is produced for discarded commands.
- Command push: occurs on an edge where cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH), driven combinationally from registered count.
  - Push when full is impossible. cmd_valid while not ready holds; no loss, no duplication.
- Pop/push interaction:
  - Push and pop on the same edge: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: if count>0, pop head into alu_a/alu_b/alu_control, go to ISSUE. Else stay. A command pushed at edge N into an empty FIFO is popped at edge N+1 (no bypass).
  - ISSUE: alu_* stable for the full cycle. At the next edge, capture alu_out→rsp_data, alu_zero→rsp_zero, alu_control→rsp_op; set rsp_valid=1; go to HOLD.
  - HOLD: rsp_valid and rsp_* held stable until rsp_ready=1.
    - On the handshake edge, if count>0, pop the next command into alu_* and go to ISSUE (rsp_valid=0 the following cycle). Else go to IDLE with rsp_valid=0.
    - alu_* keep the last issued values while in HOLD and IDLE.
- Latency: rsp_valid rises 3 edges after command acceptance (push, pop, capture) from idle.
- Throughput: one result per 2 cycles with rsp_ready tied high.
- Results return in command order. Arithmetic is entirely the alu's; no width change or modification of captured values.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
- Macro: ALU_SEQ_ZERO_CHECK_EN.
- Defined: adds output port zero_err (1 bit).
  - Set at the ISSUE capture edge when alu_zero != (alu_out == 0).
  - Sticky until reset; reset value 0.
- Undefined: port zero_err and its logic are absent; all other behaviour identical.

Test Plan:
- Bench setup: codebase alu instantiated as responder.
- Single op, rsp_ready=1: push A=0001, B=0002, op=010 → rsp_valid exactly 3 edges after push; rsp_data=0003, rsp_zero=0, rsp_op=010.
- Back-to-back ordering: push (0004,0002,011), (F333,0CCC,000), (F333,0CCC,001) on consecutive cycles.
  - Responses arrive in order: 0002; 0000 with zero=1; FFFF.
  - Spacing is 2 cycles with rsp_ready=1.
- Full/backpressure: rsp_ready=0, push 6 commands with cmd_valid held.
  - count reaches 4 with one result held; cmd_ready=0.
  - Excess command is not lost.
  - Release rsp_ready → all 6 responses delivered in order, each rsp_* stable while stalled.
- Simultaneous push/pop at count=2: count stays 2; wrap across pointer boundary verified with 10 sequential ops.
- Reset mid-operation: assert reset in HOLD with count=3 → next cycle rsp_valid=0, count=0, busy=0; no stale response after reset.
- With ALU_SEQ_ZERO_CHECK_EN: force alu_zero=1 while alu_out=0005 → zero_err=1 after the capture edge, stays 1; cleared only by reset.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a small FIFO, issues them one at a
// time to a combinational ALU, captures Out/Zero and returns results in order.
// Optional: define ALU_SEQ_ZERO_CHECK_EN to add the sticky zero_err output,
// which flags an ALU whose Zero flag disagrees with its Out value.
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [WIDTH-1:0]       cmd_a,
   input  logic [WIDTH-1:0]       cmd_b,
   input  logic [2:0]             cmd_op,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [2:0]             alu_control,
   input  logic [WIDTH-1:0]       alu_out,
   input  logic                   alu_zero,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_zero,
   output logic [2:0]             rsp_op,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
`ifdef ALU_SEQ_ZERO_CHECK_EN
   ,
   output logic                   zero_err
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] mem_a  [DEPTH];
   logic [WIDTH-1:0] mem_b  [DEPTH];
   logic [2:0]       mem_op [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push, pop, nonempty;

   assign nonempty  = (count_q != '0);
   assign cmd_ready = (count_q != CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign count     = count_q;
   assign busy      = (state_q != IDLE) || nonempty;

   // Next-state logic; pop only ever fires with a non-empty FIFO.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (nonempty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = HOLD;
         HOLD: begin
            if (rsp_ready) begin
               if (nonempty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage; contents are meaningless once pointers/count are reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr_q]  <= cmd_a;
         mem_b[wr_ptr_q]  <= cmd_b;
         mem_op[wr_ptr_q] <= cmd_op;
      end
   end

   // FSM state, FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ALU operand registers: load on pop, otherwise keep the last issued command.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= '0;
      end else if (pop) begin
         alu_a       <= mem_a[rd_ptr_q];
         alu_b       <= mem_b[rd_ptr_q];
         alu_control <= mem_op[rd_ptr_q];
      end
   end

   // Response capture at the end of ISSUE, held until the consumer accepts.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_op    <= '0;
      end else if (state_q == ISSUE) begin
         rsp_valid <= 1'b1;
         rsp_data  <= alu_out;
         rsp_zero  <= alu_zero;
         rsp_op    <= alu_control;
      end else if ((state_q == HOLD) && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef ALU_SEQ_ZERO_CHECK_EN
   // Sticky flag: ALU Zero output inconsistent with its result at capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_err <= 1'b0;
      end else if ((state_q == ISSUE) && (alu_zero != (alu_out == '0))) begin
         zero_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU
// responder (000 AND, 001 OR, 010 ADD, 011 SUB).
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_control;
   logic [15:0] alu_out;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_zero;
   logic [2:0]  rsp_op;
   logic        busy;
   logic [2:0]  count;
   logic        force_zero;
`ifdef ALU_SEQ_ZERO_CHECK_EN
   logic        zero_err;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [15:0] exp_data[$];
   logic        exp_zero[$];
   logic [2:0]  exp_op[$];
   logic [15:0] got_data[$];
   logic        got_zero[$];
   logic [2:0]  got_op[$];
   int          got_cyc[$];

   alu_op_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
      .busy(busy), .count(count)
`ifdef ALU_SEQ_ZERO_CHECK_EN
      , .zero_err(zero_err)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural ALU responder.
   always_comb begin
      case (alu_control)
         3'b000:  alu_out = alu_a & alu_b;
         3'b001:  alu_out = alu_a | alu_b;
         3'b010:  alu_out = alu_a + alu_b;
         3'b011:  alu_out = alu_a - alu_b;
         default: alu_out = '0;
      endcase
      alu_zero = force_zero | (alu_out == 16'h0000);
   end

   // Cycle counter and response logger.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && rsp_valid && rsp_ready) begin
         got_data.push_back(rsp_data);
         got_zero.push_back(rsp_zero);
         got_op.push_back(rsp_op);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      exp_data.delete(); exp_zero.delete(); exp_op.delete();
      got_data.delete(); got_zero.delete(); got_op.delete(); got_cyc.delete();
   endtask

   // Present a command and hold it until accepted; cmd_valid is left high.
   task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                           input logic [15:0] ed, input logic ez);
      logic acc;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      exp_data.push_back(ed);
      exp_zero.push_back(ez);
      exp_op.push_back(op);
      for (int k = 0; k < 50; k++) begin
         acc = cmd_ready;
         tick();
         if (acc) return;
      end
      check("push_timeout", 32'd0, 32'd1);
   endtask

   // Wait (bounded) for n logged responses and compare them in order.
   task automatic check_rsp(input string tag, input int n);
      for (int k = 0; k < 300 && got_data.size() < n; k++) tick();
      check({tag, "_count"}, 32'(got_data.size()), 32'(n));
      for (int i = 0; i < n && i < got_data.size() && i < exp_data.size(); i++) begin
         check({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
         check({tag, "_zero"}, 32'(got_zero[i]), 32'(exp_zero[i]));
         check({tag, "_op"},   32'(got_op[i]),   32'(exp_op[i]));
      end
   endtask

   initial begin
      logic acc;
      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b0; force_zero = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_control", 32'(alu_control), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_op", 32'(rsp_op), 32'd0);
`ifdef ALU_SEQ_ZERO_CHECK_EN
      check("rst_zero_err", 32'(zero_err), 32'd0);
`endif

      // Single op: push, pop, capture on three successive edges.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_a = 16'h0001; cmd_b = 16'h0002; cmd_op = 3'b010;
      tick();
      cmd_valid = 1'b0;
      check("s1_count", 32'(count), 32'd1);
      check("s1_rsp_valid", 32'(rsp_valid), 32'd0);
      check("s1_busy", 32'(busy), 32'd1);
      tick();
      check("s2_alu_a", 32'(alu_a), 32'h0001);
      check("s2_alu_b", 32'(alu_b), 32'h0002);
      check("s2_alu_control", 32'(alu_control), 32'd2);
      check("s2_rsp_valid", 32'(rsp_valid), 32'd0);
      check("s2_count", 32'(count), 32'd0);
      tick();
      check("s3_rsp_valid", 32'(rsp_valid), 32'd1);
      check("s3_rsp_data", 32'(rsp_data), 32'h0003);
      check("s3_rsp_zero", 32'(rsp_zero), 32'd0);
      check("s3_rsp_op", 32'(rsp_op), 32'd2);
      tick();
      check("s4_rsp_valid", 32'(rsp_valid), 32'd0);
      check("s4_busy", 32'(busy), 32'd0);
      check("s4_alu_a_kept", 32'(alu_a), 32'h0001);
      clear_q();

      // Back-to-back ordering and 2-cycle spacing.
      push_cmd(16'h0004, 16'h0002, 3'b011, 16'h0002, 1'b0);
      push_cmd(16'hF333, 16'h0CCC, 3'b000, 16'h0000, 1'b1);
      push_cmd(16'hF333, 16'h0CCC, 3'b001, 16'hFFFF, 1'b0);
      cmd_valid = 1'b0;
      check_rsp("b2b", 3);
      if (got_cyc.size() == 3) begin
         check("b2b_gap0", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
         check("b2b_gap1", 32'(got_cyc[2] - got_cyc[1]), 32'd2);
      end
      clear_q();

      // Full FIFO with a stalled consumer; sixth command must wait, not vanish.
      rsp_ready = 1'b0;
      push_cmd(16'h0010, 16'h0020, 3'b010, 16'h0030, 1'b0);
      push_cmd(16'h0100, 16'h0001, 3'b011, 16'h00FF, 1'b0);
      push_cmd(16'h00F0, 16'h0F0F, 3'b000, 16'h0000, 1'b1);
      push_cmd(16'h1200, 16'h0034, 3'b001, 16'h1234, 1'b0);
      push_cmd(16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1);
      cmd_a = 16'h0005; cmd_b = 16'h0007; cmd_op = 3'b011;
      exp_data.push_back(16'hFFFE); exp_zero.push_back(1'b0); exp_op.push_back(3'b011);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("full_count", 32'(count), 32'd4);
         check("full_cmd_ready", 32'(cmd_ready), 32'd0);
         check("full_rsp_valid", 32'(rsp_valid), 32'd1);
         check("full_rsp_data", 32'(rsp_data), 32'h0030);
         check("full_rsp_op", 32'(rsp_op), 32'd2);
      end
      rsp_ready = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
         acc = cmd_ready;
         tick();
      end
      check("full_sixth_accepted", 32'(acc), 32'd1);
      cmd_valid = 1'b0;
      check_rsp("full", 6);
      clear_q();

      // Simultaneous push and pop with two entries queued.
      rsp_ready = 1'b0;
      push_cmd(16'h0007, 16'h0003, 3'b000, 16'h0003, 1'b0);
      push_cmd(16'h0008, 16'h0001, 3'b001, 16'h0009, 1'b0);
      push_cmd(16'h000A, 16'h000A, 3'b011, 16'h0000, 1'b1);
      check("pp_count_before", 32'(count), 32'd2);
      rsp_ready = 1'b1;
      push_cmd(16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0);
      cmd_valid = 1'b0;
      check("pp_count_after", 32'(count), 32'd2);
      check_rsp("pp", 4);
      clear_q();

      // Ten sequential adds, wrapping the pointers more than twice.
      for (int i = 0; i < 10; i++) begin
         logic [15:0] a, b, s;
         a = 16'(i * 16'h1111);
         b = 16'(i);
         s = 16'(i * 16'h1111 + i);
         push_cmd(a, b, 3'b010, s, s == 16'h0000);
      end
      cmd_valid = 1'b0;
      check_rsp("wrap", 10);
      clear_q();

      // Reset while holding a result with three commands queued.
      rsp_ready = 1'b0;
      push_cmd(16'h0001, 16'h0001, 3'b010, 16'h0002, 1'b0);
      push_cmd(16'h0002, 16'h0001, 3'b010, 16'h0003, 1'b0);
      push_cmd(16'h0003, 16'h0001, 3'b010, 16'h0004, 1'b0);
      push_cmd(16'h0004, 16'h0001, 3'b010, 16'h0005, 1'b0);
      cmd_valid = 1'b0;
      check("mid_count", 32'(count), 32'd3);
      check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      clear_q();
      rsp_ready = 1'b1;
      repeat (10) tick();
      check("mid_no_stale_rsp", 32'(got_data.size()), 32'd0);
      check("mid_idle_busy", 32'(busy), 32'd0);
      clear_q();

`ifdef ALU_SEQ_ZERO_CHECK_EN
      // Inconsistent Zero flag from the ALU sets the sticky error.
      force_zero = 1'b1;
      push_cmd(16'h0002, 16'h0003, 3'b010, 16'h0005, 1'b1);
      cmd_valid = 1'b0;
      check_rsp("zerr", 1);
      force_zero = 1'b0;
      check("zerr_set", 32'(zero_err), 32'd1);
      repeat (3) tick();
      check("zerr_sticky", 32'(zero_err), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("zerr_cleared", 32'(zero_err), 32'd0);
      clear_q();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
